clk_ratio_monitor: RTL and testbench

Receive-side companion to the even/odd clock dividers. It samples a divided clock generated in the `clk` domain and measures its period and high time in `clk` cycles. It declares lock once the ratio is stable and flags ratio changes, duty-cycle errors and a stopped divided clock. It sits next to each divider instance as a built-in self-check and as the status source for the clock-control registers.

---
 rtl/clk_ratio_monitor.sv | 169 ++++++++++++++++
 tb/tb_clk_ratio_monitor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a clk-synchronous divided clock and
// reports lock, ratio changes, duty-cycle errors and a stopped clock.
module clk_ratio_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             ratio_err,
    output logic             duty_err,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
    localparam logic signed [CNT_W+1:0] ONE_S = (CNT_W+2)'(1);

    state_t           state_q, state_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] ref_period_q, ref_period_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             ratio_err_q, ratio_err_d;
    logic             duty_err_q, duty_err_d;
    logic             timeout_q, timeout_d;

    logic                    rise;
    logic                    fall;
    logic [CNT_W-1:0]        run_inc;
    logic signed [CNT_W+1:0] duty_diff;
    logic                    duty_bad;

    assign rise    = div_in & ~div_q;
    assign fall    = ~div_in & div_q;
    assign run_inc = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + 1'b1;

    // 2*high - period, evaluated on the values captured at this rise
    assign duty_diff = $signed({1'b0, hi_cap_q, 1'b0})
                     - $signed({2'b00, run_cnt_q});
    assign duty_bad  = (duty_diff > ONE_S) || (duty_diff < -ONE_S);

    always_comb begin
        state_d      = state_q;
        div_d        = div_in;
        run_cnt_d    = run_cnt_q;
        hi_cap_d     = hi_cap_q;
        ref_period_d = ref_period_q;
        match_cnt_d  = match_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        ratio_err_d  = 1'b0;
        duty_err_d   = duty_err_q;
        timeout_d    = timeout_q;

        if (!enable) begin
            state_d      = IDLE;
            run_cnt_d    = '0;
            hi_cap_d     = '0;
            ref_period_d = '0;
            match_cnt_d  = '0;
            period_d     = '0;
            high_time_d  = '0;
            locked_d     = 1'b0;
            duty_err_d   = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            if (state_q != IDLE) begin
                run_cnt_d = rise ? CNT_W'(1) : run_inc;
                if (fall) hi_cap_d = run_cnt_q;
            end
            unique case (state_q)
                IDLE: state_d = ACQ;
                ACQ: begin
                    if (rise) state_d = MEAS;
                end
                MEAS, LOCKED: begin
                    if (rise) begin
                        period_d     = run_cnt_q;
                        high_time_d  = hi_cap_q;
                        meas_valid_d = 1'b1;
                        duty_err_d   = duty_bad;
                        if (state_q == MEAS) begin
                            if (match_cnt_q == '0 ||
                                run_cnt_q != ref_period_q) begin
                                ref_period_d = run_cnt_q;
                                match_cnt_d  = 4'd1;
                                ratio_err_d  = (match_cnt_q != '0);
                            end else begin
                                match_cnt_d = match_cnt_q + 4'd1;
                            end
                            if (match_cnt_d == LOCK_N) begin
                                locked_d = 1'b1;
                                state_d  = LOCKED;
                            end
                        end else if (run_cnt_q != ref_period_q) begin
                            ratio_err_d  = 1'b1;
                            locked_d     = 1'b0;
                            ref_period_d = run_cnt_q;
                            match_cnt_d  = 4'd1;
                            state_d      = MEAS;
                        end
                    end else if (run_cnt_q == TO_VAL) begin
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                        state_d     = ACQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            div_q        <= 1'b0;
            run_cnt_q    <= '0;
            hi_cap_q     <= '0;
            ref_period_q <= '0;
            match_cnt_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            ratio_err_q  <= 1'b0;
            duty_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            run_cnt_q    <= run_cnt_d;
            hi_cap_q     <= hi_cap_d;
            ref_period_q <= ref_period_d;
            match_cnt_q  <= match_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            ratio_err_q  <= ratio_err_d;
            duty_err_q   <= duty_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign ratio_err  = ratio_err_q;
    assign duty_err   = duty_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: directed and random divided-clock waveforms
// checked cycle by cycle against an event-level reference model.
module tb_clk_ratio_monitor;
    localparam int CNT_W      = 8;
    localparam int LOCK_COUNT = 3;
    localparam int TIMEOUT    = 255;
    localparam int VW         = 2 * CNT_W + 5;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             enable = 1'b0;
    logic             div_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             ratio_err;
    logic             duty_err;
    logic             timeout;

    clk_ratio_monitor #(
        .CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .div_in(div_in),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .locked(locked), .ratio_err(ratio_err), .duty_err(duty_err),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: mode 0 off, 1 waiting for first rise, 2 measuring
    int   cyc = 0;
    int   m_mode = 0;
    int   m_last_rise = 0;
    int   m_last_fall = 0;
    logic m_prev = 1'b0;
    int   periods[$];
    int   e_period = 0;
    int   e_high = 0;
    logic e_mv = 0, e_re = 0, e_duty = 0, e_locked = 0, e_timeout = 0;

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {period, high_time, meas_valid, locked, ratio_err,
                duty_err, timeout};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {CNT_W'(e_period), CNT_W'(e_high), e_mv, e_locked, e_re,
                e_duty, e_timeout};
    endfunction

    task automatic model_clear();
        m_mode = 0;
        periods.delete();
        e_period = 0; e_high = 0;
        e_mv = 0; e_re = 0; e_duty = 0; e_locked = 0; e_timeout = 0;
    endtask

    task automatic model_edge();
        logic rise, fall;
        int run, p, h, s, d;
        rise = div_in && !m_prev;
        fall = !div_in && m_prev;
        m_prev = div_in;
        cyc++;
        e_mv = 0;
        e_re = 0;
        if (!enable) begin
            model_clear();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rise) begin
                m_mode = 2;
                m_last_rise = cyc;
                periods.delete();
            end
        end else begin
            run = cyc - m_last_rise;
            if (fall) m_last_fall = cyc;
            if (rise) begin
                p = sat(run);
                h = sat(m_last_fall - m_last_rise);
                d = 2 * h - p;
                e_period = p;
                e_high = h;
                e_mv = 1;
                e_duty = (d > 1 || d < -1);
                if (periods.size() > 0 && periods[$] != p) e_re = 1;
                periods.push_back(p);
                if (periods.size() > 32) void'(periods.pop_front());
                s = 0;
                for (int i = periods.size() - 1; i >= 0; i--) begin
                    if (periods[i] != p) break;
                    s++;
                end
                e_locked = (s >= LOCK_COUNT);
                m_last_rise = cyc;
            end else if (run == TIMEOUT) begin
                e_timeout = 1;
                e_locked = 0;
                m_mode = 1;
                periods.delete();
            end
        end
    endtask

    task automatic tick(input logic v);
        div_in = v;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(i[0]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL idle_disabled c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_div4();
        int mv = 0, re = 0;
        enable = 1'b1;
        for (int c = 0; c < 22; c++) begin
            tick(c < 2 ? 1'b0 : ((c - 2) % 4) < 2);
            mv += meas_valid;
            re += ratio_err;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL div4 c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (mv != 4 || re != 0 || locked !== 1'b1 || period !== 8'd4 ||
            high_time !== 8'd2 || duty_err !== 1'b0) begin
            fails++;
            $display("FAIL div4_summary: mv=%0d re=%0d lk=%b p=%0d h=%0d",
                     mv, re, locked, period, high_time);
        end
    endtask

    task automatic test_switch();
        int re = 0, unl = 0;
        for (int c = 0; c < 30; c++) begin
            tick((c % 6) < 3);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL div6 c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (locked !== 1'b1 || period !== 8'd6) begin
            fails++;
            $display("FAIL div6_lock: lk=%b p=%0d want 1/6", locked, period);
        end
        for (int c = 0; c < 40; c++) begin
            tick((c % 8) < 4);
            re += ratio_err;
            unl += !locked;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL div8 c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (re != 1 || unl != 16 || locked !== 1'b1 || period !== 8'd8) begin
            fails++;
            $display("FAIL div8_relock: re=%0d unl=%0d lk=%b p=%0d want 1/16/1/8",
                     re, unl, locked, period);
        end
    endtask

    task automatic test_odd();
        for (int c = 0; c < 30; c++) begin
            tick((c % 5) < 2);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL div5 c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (period !== 8'd5 || high_time !== 8'd2 || duty_err !== 1'b0) begin
            fails++;
            $display("FAIL div5_duty_ok: p=%0d h=%0d d=%b want 5/2/0",
                     period, high_time, duty_err);
        end
        for (int c = 0; c < 15; c++) begin
            tick((c % 5) < 1);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL div5_skew c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (period !== 8'd5 || high_time !== 8'd1 || duty_err !== 1'b1) begin
            fails++;
            $display("FAIL div5_duty_bad: p=%0d h=%0d d=%b want 5/1/1",
                     period, high_time, duty_err);
        end
    endtask

    task automatic test_timeout();
        int rise_cyc = 0, to_at = -1;
        logic pv = div_in;
        for (int c = 0; c < 24; c++) begin
            tick((c % 4) < 2);
            if (div_in && !pv) rise_cyc = cyc;
            pv = div_in;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL to_lock c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        for (int c = 0; c < 300; c++) begin
            tick(1'b0);
            if (timeout && to_at < 0) to_at = cyc - rise_cyc;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL to_hold c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (to_at != 255 || timeout !== 1'b1 || locked !== 1'b0) begin
            fails++;
            $display("FAIL timeout_at: at=%0d to=%b lk=%b want 255/1/0",
                     to_at, timeout, locked);
        end
        for (int c = 0; c < 8; c++) tick((c % 4) < 2);
        tests++;
        if (timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got %b want 1", timeout);
        end
        enable = 1'b0;
        tick(1'b0);
        tests++;
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL timeout_clear: got %h want 0", dut_vec());
        end
    endtask

    task automatic test_enable_off();
        int mv = 0;
        enable = 1'b1;
        for (int c = 0; c < 22; c++) tick(c < 2 ? 1'b0 : ((c - 2) % 4) < 2);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL en_prelock: got %b want 1", locked);
        end
        enable = 1'b0;
        tick(1'b1);
        tests++;
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL en_off: got %h want 0", dut_vec());
        end
        tick(1'b0);
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(c < 2 ? 1'b0 : ((c - 2) % 4) < 2);
            mv += meas_valid;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL en_reacq c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
        tests++;
        if (mv != 1) begin
            fails++;
            $display("FAIL en_first_rise: meas=%0d want 1", mv);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 16; c++) tick((c % 4) < 2);
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL async_reset: got %h want 0", dut_vec());
        end
        model_clear();
        m_prev = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 26; c++) begin
            tick(c < 2 ? 1'b0 : ((c - 2) % 4) < 2);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL post_reset c%0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int hi, lo, reps;
        for (int r = 0; r < 60; r++) begin
            hi = $urandom_range(1, 5);
            lo = $urandom_range(1, 5);
            reps = $urandom_range(1, 6);
            if ($urandom_range(0, 9) == 0) begin
                enable = 1'b0;
                tick($urandom_range(0, 1) == 1);
                tests++;
                if (dut_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL rnd_disable c%0d: got %h want %h",
                             cyc, dut_vec(), exp_vec());
                end
                enable = 1'b1;
            end
            for (int c = 0; c < reps * (hi + lo); c++) begin
                tick((c % (hi + lo)) < hi);
                tests++;
                if (dut_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL rnd h%0d l%0d c%0d: got %h want %h",
                             hi, lo, cyc, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_div4();
        test_switch();
        test_odd();
        test_timeout();
        test_enable_off();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
